mem_access_unit: RTL and testbench

Load/store alignment stage placed between the EX/MEM pipeline register and the word-addressed data memory.
Accepts one byte-addressed load or store per request. Stores of bytes and halfwords are done as a read-modify-write on the memory's single word port. Load data is sign- or zero-extended. Misaligned, out-of-range and illegal requests are reported as faults and never touch memory.

---
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the load/store alignment stage.
// The slave modport is the alignment unit. The master modport is its environment:
// the EX/MEM side that issues requests and the data memory that returns read data.
interface mem_access_unit_if #(
   parameter int WORD_ADDR_W = 8
) ();
   // request side
   logic                   req_valid;
   logic                   req_ready;
   logic [5:0]             opcode;
   logic [31:0]            addr;
   logic [31:0]            store_data;
   // response side
   logic [31:0]            load_data;
   logic                   load_valid;
   logic                   fault;
   logic [1:0]             fault_cause;
   // data memory side
   logic [WORD_ADDR_W-1:0] mem_addr;
   logic                   mem_re;
   logic                   mem_we;
   logic [31:0]            mem_wdata;
   logic [31:0]            mem_rdata;

   modport master (
      output req_valid, opcode, addr, store_data, mem_rdata,
      input  req_ready, load_data, load_valid, fault, fault_cause,
             mem_addr, mem_re, mem_we, mem_wdata
   );

   modport slave (
      input  req_valid, opcode, addr, store_data, mem_rdata,
      output req_ready, load_data, load_valid, fault, fault_cause,
             mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store alignment stage between the EX/MEM register and a word-addressed
// data memory with a single synchronous port. Sub-word stores are done as a
// read-modify-write; loads are sign- or zero-extended from the selected lane.
// Faulting requests never reach memory.
module mem_access_unit #(
   parameter int WORD_ADDR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_access_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RD   = 2'b01;
   localparam logic [1:0] CAP  = 2'b10;
   localparam logic [1:0] WR   = 2'b11;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE    = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   logic [1:0]             state;
   logic [5:0]             opcodeP0;
   logic [WORD_ADDR_W+1:0] addrP0;       // only the in-range byte address bits matter after acceptance
   logic [15:0]            storeLaneP0;  // sw bypasses the merge, so only the low halfword is kept
   logic                   opLegal;
   logic                   opHalf;
   logic                   opWord;
   logic                   misaligned;
   logic                   outOfRange;
   logic                   isLoadP0;

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   function automatic logic [31:0] extractLoad(input logic [5:0]  op,
                                               input logic [31:0] word,
                                               input logic [1:0]  offset);
      logic signed [7:0]  byteS;
      logic signed [15:0] halfS;
      logic signed [31:0] ext;
      byteS = word[{offset, 3'b000} +: 8];
      halfS = offset[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   ext = 32'(byteS);
         OP_LH:   ext = 32'(halfS);
         OP_LBU:  ext = {24'd0, byteS};
         OP_LHU:  ext = {16'd0, halfS};
         default: ext = word;
      endcase
      return ext;
   endfunction

   // Replace the addressed byte or halfword lane, leaving the other lanes intact.
   function automatic logic [31:0] mergeStore(input logic [5:0]  op,
                                              input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  offset);
      logic [31:0] merged;
      merged = word;
      if (op == OP_SH) begin
         if (offset[1]) merged[31:16] = data;
         else           merged[15:0]  = data;
      end else begin
         merged[{offset, 3'b000} +: 8] = data[7:0];
      end
      return merged;
   endfunction

   assign opLegal    = bus.opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
   assign opHalf     = bus.opcode inside {OP_LH, OP_LHU, OP_SH};
   assign opWord     = bus.opcode inside {OP_LW, OP_SW};
   assign misaligned = (opHalf && bus.addr[0]) || (opWord && (bus.addr[1:0] != 2'b00));
   assign outOfRange = |bus.addr[31:WORD_ADDR_W+2];
   assign isLoadP0   = opcodeP0 inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

   // Strobes decode straight from the state so an async reset drops them at once.
   assign bus.req_ready = (state == IDLE) && rst_n;
   assign bus.mem_re    = (state == RD);
   assign bus.mem_we    = (state == WR);
   assign bus.mem_addr  = addrP0[WORD_ADDR_W+1:2];

   // Request acceptance, fault reporting, lane extract/merge and the access sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         opcodeP0        <= '0;
         addrP0          <= '0;
         storeLaneP0     <= '0;
         bus.load_data   <= '0;
         bus.load_valid  <= 1'b0;
         bus.fault       <= 1'b0;
         bus.fault_cause <= 2'b00;
         bus.mem_wdata   <= '0;
      end else begin
         bus.load_valid <= 1'b0;
         bus.fault      <= 1'b0;
         case (state)
            // accept: latch the request and either fault or start the access
            IDLE: begin
               if (bus.req_valid) begin
                  opcodeP0    <= bus.opcode;
                  addrP0      <= bus.addr[WORD_ADDR_W+1:0];
                  storeLaneP0 <= bus.store_data[15:0];
                  if (!opLegal) begin
                     bus.fault       <= 1'b1;
                     bus.fault_cause <= CAUSE_ILLEGAL;
                  end else if (misaligned) begin
                     bus.fault       <= 1'b1;
                     bus.fault_cause <= CAUSE_MISALIGN;
                  end else if (outOfRange) begin
                     bus.fault       <= 1'b1;
                     bus.fault_cause <= CAUSE_RANGE;
                  end else if (bus.opcode == OP_SW) begin
                     bus.mem_wdata <= bus.store_data;
                     state         <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            // read strobe is up for this one cycle
            RD: state <= CAP;
            // capture: read data is valid, extract a load or merge a sub-word store
            CAP: begin
               if (isLoadP0) begin
                  bus.load_data  <= extractLoad(opcodeP0, bus.mem_rdata, addrP0[1:0]);
                  bus.load_valid <= 1'b1;
                  state          <= IDLE;
               end else begin
                  bus.mem_wdata <= mergeStore(opcodeP0, bus.mem_rdata, storeLaneP0, addrP0[1:0]);
                  state         <= WR;
               end
            end
            // write strobe is up for this one cycle
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized loads/stores/faults
// compared against a byte-level reference model of the data memory.
module tb_mem_access_unit;
   localparam int WORD_ADDR_W = 8;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   logic clk;
   logic rst_n;

   mem_access_unit_if #(.WORD_ADDR_W(WORD_ADDR_W)) bus ();

   mem_access_unit #(.WORD_ADDR_W(WORD_ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem    [256];
   logic [31:0] refMem [256];
   logic        preWe;
   logic [7:0]  preAddr;
   logic [31:0] preData;
   logic [31:0] modelLoad;
   logic [1:0]  modelCause;
   logic [5:0]  opList [8];
   int          nChecks;
   int          nPass;
   int          weCount   = 0;
   int          bothCount = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data memory: synchronous read, write on the strobe, plus a preload port
   always @(posedge clk) begin
      if (preWe) mem[preAddr] <= preData;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // strobe activity seen at each edge
   always @(posedge clk) begin
      if (bus.mem_we) weCount++;
      if (bus.mem_we && bus.mem_re) bothCount++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else nPass++;
   endtask

   // ---- reference model ----
   function automatic int opSize(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   function automatic bit isLoad(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic [1:0] expCause(input logic [5:0] op, input logic [31:0] a);
      int sz;
      sz = opSize(op);
      if (sz == 0) return 2'd3;
      if ((a % 32'(sz)) != 0) return 2'd1;
      if (a >= 32'(4 * (1 << WORD_ADDR_W))) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] modelLoadValue(input logic [5:0] op, input logic [31:0] a);
      logic [31:0] v;
      v = refMem[int'(a / 4)] >> (8 * int'(a % 4));
      case (op)
         OP_LB:  begin v = v & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
         OP_LBU: v = v & 32'hFF;
         OP_LH:  begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
         OP_LHU: v = v & 32'hFFFF;
         default: ;
      endcase
      return v;
   endfunction

   task automatic modelStore(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      int          idx;
      int          sh;
      logic [31:0] mask;
      idx  = int'(a / 4);
      sh   = 8 * int'(a % 4);
      mask = (opSize(op) == 1) ? 32'hFF : (opSize(op) == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      refMem[idx] = (refMem[idx] & ~(mask << sh)) | ((d & mask) << sh);
   endtask

   // {load_valid, fault, mem_re, mem_we, req_ready} for the four cycles after acceptance
   function automatic logic [19:0] expPattern(input logic [5:0] op, input logic [1:0] cause);
      if (cause != 2'd0) return {5'b01001, 5'b00001, 5'b00001, 5'b00001};
      if (isLoad(op))    return {5'b00100, 5'b00000, 5'b10001, 5'b00001};
      if (op == OP_SW)   return {5'b00010, 5'b00001, 5'b00001, 5'b00001};
      return {5'b00100, 5'b00000, 5'b00010, 5'b00001};
   endfunction

   task automatic preload(input int w, input logic [31:0] v);
      preWe   = 1'b1;
      preAddr = 8'(w);
      preData = v;
      @(negedge clk);
      preWe       = 1'b0;
      refMem[w]   = v;
   endtask

   // issue one request from a negedge, trace four cycles, then compare with the model
   task automatic runReq(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      logic [19:0] obs;
      logic [1:0]  cause;
      int          waitCnt;
      bus.opcode     = op;
      bus.addr       = a;
      bus.store_data = d;
      bus.req_valid  = 1'b1;
      waitCnt = 0;
      while (!bus.req_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 20) begin
         checkEq("acceptTimeout", 32'(waitCnt), 32'd0);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      obs = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) bus.req_valid = 1'b0;
         obs = {obs[14:0], bus.load_valid, bus.fault, bus.mem_re, bus.mem_we, bus.req_ready};
      end
      cause = expCause(op, a);
      checkEq("cycleTrace", 32'(obs), 32'(expPattern(op, cause)));
      if (cause != 2'd0) begin
         modelCause = cause;
      end else if (isLoad(op)) begin
         modelLoad = modelLoadValue(op, a);
      end else begin
         modelStore(op, a, d);
         checkEq("memWord", mem[int'(a / 4)], refMem[int'(a / 4)]);
      end
      checkEq("loadData", bus.load_data, modelLoad);
      checkEq("faultCause", 32'(bus.fault_cause), 32'(modelCause));
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] a;
      int          weMark;
      int          waitCnt;
      nChecks = 0;
      nPass   = 0;
      opList  = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
      bus.req_valid  = 1'b0;
      bus.opcode     = '0;
      bus.addr       = '0;
      bus.store_data = '0;
      preWe      = 1'b0;
      preAddr    = '0;
      preData    = '0;
      modelLoad  = '0;
      modelCause = '0;
      rst_n      = 1'b0;
      for (int i = 0; i < 256; i++) refMem[i] = '0;

      @(negedge clk);
      preload(0, 32'h8899_AABB);
      preload(1, 32'h0000_0000);
      preload(2, 32'h1122_3344);
      preload(3, 32'h0000_0000);
      preload(4, 32'h5566_7788);
      preload(5, 32'h0102_0304);

      // reset state
      checkEq("rstReady", 32'(bus.req_ready), 32'd0);
      checkEq("rstLoadValid", 32'(bus.load_valid), 32'd0);
      checkEq("rstFault", 32'(bus.fault), 32'd0);
      checkEq("rstCause", 32'(bus.fault_cause), 32'd0);
      checkEq("rstLoadData", bus.load_data, 32'd0);
      checkEq("rstMemRe", 32'(bus.mem_re), 32'd0);
      checkEq("rstMemWe", 32'(bus.mem_we), 32'd0);
      checkEq("rstWdata", bus.mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkEq("readyAfterRst", 32'(bus.req_ready), 32'd1);

      // loads from word 0 = 0x8899AABB
      runReq(OP_LB, 32'h1, 32'h0);  checkEq("lbValue", bus.load_data, 32'hFFFF_FFAA);
      runReq(OP_LBU, 32'h1, 32'h0); checkEq("lbuValue", bus.load_data, 32'h0000_00AA);
      runReq(OP_LH, 32'h2, 32'h0);  checkEq("lhValue", bus.load_data, 32'hFFFF_8899);
      runReq(OP_LHU, 32'h2, 32'h0); checkEq("lhuValue", bus.load_data, 32'h0000_8899);
      runReq(OP_LW, 32'h0, 32'h0);  checkEq("lwValue", bus.load_data, 32'h8899_AABB);

      // stores
      runReq(OP_SB, 32'h6, 32'h1234_5677); checkEq("sbWord", mem[1], 32'h0077_0000);
      runReq(OP_LW, 32'h4, 32'h0);         checkEq("lwAfterSb", bus.load_data, 32'h0077_0000);
      runReq(OP_SH, 32'hA, 32'h0000_BEEF); checkEq("shWord", mem[2], 32'hBEEF_3344);
      runReq(OP_SW, 32'hC, 32'hCAFE_F00D); checkEq("swWord", mem[3], 32'hCAFE_F00D);

      // faults
      runReq(OP_LW, 32'h2, 32'h0);   checkEq("misalignCause", 32'(bus.fault_cause), 32'd1);
      runReq(OP_LH, 32'h400, 32'h0); checkEq("rangeCause", 32'(bus.fault_cause), 32'd2);
      runReq(6'b000000, 32'h3, 32'h0); checkEq("illegalCause", 32'(bus.fault_cause), 32'd3);

      // reset during the capture cycle of an sb
      weMark         = weCount;
      bus.opcode     = OP_SB;
      bus.addr       = 32'h11;
      bus.store_data = 32'h0000_00EE;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkEq("rstMidReady", 32'(bus.req_ready), 32'd0);
      checkEq("rstMidWdata", bus.mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      checkEq("rstMidMemWe", 32'(bus.mem_we), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkEq("rstMidReadyAfter", 32'(bus.req_ready), 32'd1);
      checkEq("rstMidWrites", 32'(weCount - weMark), 32'd0);
      checkEq("rstMidWord", mem[4], 32'h5566_7788);
      modelLoad  = '0;
      modelCause = '0;

      // back-to-back: sb held then lw to the same word
      weMark         = weCount;
      bus.opcode     = OP_SB;
      bus.addr       = 32'h15;
      bus.store_data = 32'h0000_00A5;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.opcode     = OP_LW;
      bus.addr       = 32'h14;
      bus.store_data = 32'h0;
      waitCnt = 0;
      while (!bus.req_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkEq("b2bWait", 32'(waitCnt), 32'd3);
      checkEq("b2bWrites", 32'(weCount - weMark), 32'd1);
      modelStore(OP_SB, 32'h15, 32'h0000_00A5);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      waitCnt = 1;
      while (!bus.load_valid && waitCnt < 10) begin
         @(negedge clk);
         waitCnt++;
      end
      checkEq("b2bLatency", 32'(waitCnt), 32'd3);
      modelLoad = refMem[5];
      checkEq("b2bLoad", bus.load_data, modelLoad);
      checkEq("b2bLoadConst", bus.load_data, 32'h0102_A504);
      @(negedge clk);

      // randomized traffic over words 0..15
      for (int w = 0; w < 16; w++) preload(w, $urandom);
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 8) op = opList[$urandom_range(0, 7)];
         else op = 6'($urandom);
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(10, 31));
         runReq(op, a, $urandom);
      end

      checkEq("reWeExclusive", 32'(bothCount), 32'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
